// File: rtl/fifo_drain_ctrl.sv
// Burst read controller: pops a fixed-length burst from a sync FIFO and
// streams it out through a 2-entry skid buffer that hides the read latency.
module fifo_drain_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int LEN_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  start,
    input  logic [LEN_W-1:0]      burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_rd_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        issue_q, issue_d;
    logic [LEN_W-1:0]        dlv_q, dlv_d;
    logic [1:0]              occ_q, occ_d;
    logic                    infl_q, infl_d;
    logic [DATA_WIDTH-1:0]   head_q, head_d;
    logic [DATA_WIDTH-1:0]   tail_q, tail_d;
    logic                    hs;
    logic [1:0]              pend;

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = head_q;
    assign m_last  = m_valid && (dlv_q == len_q - LEN_W'(1));
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign hs      = m_valid && m_ready;

    // Slots committed after this edge: buffered + in flight - leaving.
    assign pend = occ_q + {1'b0, infl_q} - {1'b0, hs};

    always_comb begin
        fifo_rd_en = (state_q == RUN) && !fifo_empty &&
                     (issue_q < len_q) && (pend < 2'd2);
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        issue_d = issue_q;
        dlv_d   = dlv_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = burst_len;
                    issue_d = '0;
                    dlv_d   = '0;
                    state_d = (burst_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                issue_d = issue_q + {{(LEN_W-1){1'b0}}, fifo_rd_en};
                dlv_d   = dlv_q + {{(LEN_W-1){1'b0}}, hs};
                if (hs && (dlv_q == len_q - LEN_W'(1))) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        infl_d = fifo_rd_en;
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case ({hs, infl_q})
            2'b10: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b01: begin
                if (occ_q == 2'd0) head_d = fifo_dout;
                else               tail_d = fifo_dout;
                occ_d = occ_q + 2'd1;
            end
            2'b11: begin
                // Head leaves while a new word lands: occupancy unchanged.
                if (occ_q == 2'd1) begin
                    head_d = fifo_dout;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_dout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
            len_q   <= '0;
            issue_q <= '0;
            dlv_q   <= '0;
            occ_q   <= '0;
            infl_q  <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            issue_q <= issue_d;
            dlv_q   <= dlv_d;
            occ_q   <= occ_d;
            infl_q  <= infl_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: behavioural FIFO, random writer and consumer,
// and a burst-level scoreboard checked every cycle.
module tb_fifo_drain_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_ = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          busy, done, fifo_rd_en, m_valid, m_last;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;

    fifo_drain_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_(rst_), .start(start), .burst_len(burst_len),
        .busy(busy), .done(done), .fifo_rd_en(fifo_rd_en),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural FIFO: pop at the edge, data visible shortly after.
    logic [DW-1:0] fq[$];
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          f_pop, f_push;
    logic [DW-1:0] f_wd;

    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            fq.delete();
            fifo_empty = 1'b1;
            fifo_dout  = '0;
        end else begin
            f_pop  = fifo_rd_en && !fifo_empty;
            f_push = wr_en;
            f_wd   = wr_data;
            #1;
            if (f_pop) fifo_dout = fq.pop_front();
            if (f_push && fq.size() < DEPTH) fq.push_back(f_wd);
            fifo_empty = (fq.size() == 0);
        end
    end

    // Writer: pushes until push_done reaches push_req, at 1/wr_div rate.
    int push_req = 0;
    int push_done = 0;
    int wr_div = 1;
    bit seq_on = 1'b0;
    int seq_base = 0;

    always @(posedge clk) begin
        #1;
        if (push_done < push_req && $urandom_range(0, wr_div - 1) == 0) begin
            wr_en   = 1'b1;
            wr_data = seq_on ? 8'(push_done - seq_base + 1) : 8'($urandom);
            push_done++;
        end else begin
            wr_en = 1'b0;
        end
    end

    // Consumer: 0 always ready, 1 pattern 1,0,0, 2 random, 3 never.
    int rdy_mode = 0;
    int rph = 0;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: m_ready = 1'b1;
            1: begin
                m_ready = (rph == 0);
                rph = (rph + 1) % 3;
            end
            2: m_ready = 1'b1 & $urandom_range(0, 1);
            default: m_ready = 1'b0;
        endcase
    end

    // Reference: burst phase, words popped/delivered, expected word order.
    logic [DW-1:0] exp_q[$];
    int phase = 0;
    int cur_len = 0;
    int pops = 0;
    int dlv = 0;
    int hs = 0;
    int done_cnt = 0;
    int hs_tot = 0;
    bit stall = 1'b0;
    logic [DW-1:0] sd;
    logic sl;

    always @(negedge clk) begin
        if (!rst_) begin
            phase = 0;
            pops  = 0;
            dlv   = 0;
            stall = 1'b0;
            exp_q.delete();
        end else begin
            hs = (m_valid && m_ready) ? 1 : 0;
            chk("busy", busy, phase != 0);
            chk("done", done, phase == 2);
            if (fifo_rd_en) begin
                chk("rd_guard", {fifo_empty, phase == 1}, 2'b01);
                chk("rd_len", pops < cur_len, 1);
                chk("ahead", (pops + 1 - dlv - hs) <= 2, 1);
            end
            if (stall) begin
                chk("hold_v", m_valid, 1);
                chk("hold_d", m_data, sd);
                chk("hold_l", m_last, sl);
            end
            if (m_valid) chk("last", m_last, (dlv + 1) == cur_len);
            if (hs != 0) begin
                if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
                else chk("data", m_data, exp_q.pop_front());
            end
            if (fifo_rd_en && !fifo_empty) begin
                exp_q.push_back(fq[0]);
                pops++;
            end
            stall = m_valid && !m_ready;
            sd = m_data;
            sl = m_last;
            if (hs != 0) begin
                dlv++;
                hs_tot++;
            end
            if (done) done_cnt++;
            case (phase)
                0: if (start) begin
                    cur_len = int'(burst_len);
                    pops = 0;
                    dlv = 0;
                    phase = (burst_len == '0) ? 2 : 1;
                end
                1: if (hs != 0 && dlv == cur_len) phase = 2;
                default: phase = 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pushed();
        for (int i = 0; i < 200 && push_done < push_req; i++) step();
        chk("push_timeout", push_done, push_req);
        step();
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end while (!done && n < 400);
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic run_burst(input int len, input int pre, input int lat);
        int n, d0, h0;
        push_req += pre;
        wait_pushed();
        push_req += len - pre;
        d0 = done_cnt;
        h0 = hs_tot;
        start = 1'b1;
        burst_len = LW'(len);
        wait_done(n);
        if (lat > 0) chk("latency", n, lat);
        step();
        step();
        chk("done_once", done_cnt - d0, 1);
        chk("words", hs_tot - h0, len);
        chk("fifo_drained", fifo_empty, 1);
    endtask

    initial begin
        int n, d0, h0, len, pre;
        repeat (2) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd", fifo_rd_en, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        rst_ = 1'b1;
        step();

        // Streaming 0x01..0x08
        seq_on = 1'b1;
        seq_base = push_done;
        rdy_mode = 0;
        run_burst(8, 8, 11);
        seq_on = 1'b0;

        // Reset with the buffer full and consumer stalled
        rdy_mode = 3;
        push_req += 8;
        wait_pushed();
        start = 1'b1;
        burst_len = LW'(8);
        step();
        start = 1'b0;
        repeat (5) step();
        chk("pre_rst_valid", m_valid, 1);
        chk("pre_rst_rd", fifo_rd_en, 0);
        rst_ = 1'b0;
        #1;
        chk("arst_valid", m_valid, 0);
        chk("arst_rd", fifo_rd_en, 0);
        chk("arst_busy", busy, 0);
        repeat (2) step();
        rst_ = 1'b1;
        repeat (2) step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_valid", m_valid, 0);

        // Backpressure 1,0,0 pattern
        rdy_mode = 1;
        run_burst(4, 4, 0);

        // Underflow stall: 2 words, refill of 3 later
        rdy_mode = 0;
        push_req += 2;
        wait_pushed();
        d0 = done_cnt;
        h0 = hs_tot;
        start = 1'b1;
        burst_len = LW'(5);
        step();
        start = 1'b0;
        repeat (10) step();
        chk("uf_stalled", hs_tot - h0, 2);
        push_req += 3;
        wait_done(n);
        repeat (2) step();
        chk("uf_done", done_cnt - d0, 1);
        chk("uf_words", hs_tot - h0, 5);

        // Boundary lengths
        run_burst(0, 0, 1);
        run_burst(16, 16, 19);

        // Start while busy is ignored
        rdy_mode = 2;
        push_req += 6;
        wait_pushed();
        d0 = done_cnt;
        h0 = hs_tot;
        start = 1'b1;
        burst_len = LW'(6);
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        burst_len = LW'(3);
        step();
        start = 1'b0;
        wait_done(n);
        repeat (2) step();
        chk("sb_done", done_cnt - d0, 1);
        chk("sb_words", hs_tot - h0, 6);

        // Random bursts
        for (int b = 0; b < 25; b++) begin
            len = $urandom_range(0, DEPTH);
            pre = $urandom_range(0, len);
            wr_div = $urandom_range(1, 4);
            rdy_mode = ($urandom_range(0, 3) == 0) ? 1 : 2;
            run_burst(len, pre, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
